spi_status_tx: RTL and testbench

SPI_STATUS_TX -- requirements
Module: spi_status_tx

---
 rtl/spi_status_tx.sv | 184 ++++++++++++++++++
 tb/tb_spi_status_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_status_tx.sv
// SPI slave (mode 0) that returns a buffered 16-bit status word on miso and
// captures the 16-bit word the ARM sends on mosi. All logic runs on pck0.
`timescale 1ns/1ps
module spi_status_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        pck0,
  input  logic        nrst,
  input  logic        spck,
  input  logic        ncs,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic        tx_busy,
  output logic [15:0] rx_word,
  output logic        rx_valid,
  output logic        underrun,
  output logic        frame_err,
  input  logic        clr_err
);

  localparam int            SETTLE      = SYNC_STAGES + 1;
  localparam int            SW          = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_DONE = SW'(SETTLE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_HIGH = 2'd2
  } state_e;

  // Bits [SYNC_STAGES-1:0] are the synchroniser, bit SYNC_STAGES is the history flop.
  logic [SYNC_STAGES:0] spck_sync_q, spck_sync_d;
  logic [SYNC_STAGES:0] ncs_sync_q,  ncs_sync_d;
  logic [SYNC_STAGES:0] mosi_sync_q, mosi_sync_d;

  state_e        state_q,     state_d;
  logic [SW-1:0] settle_q,    settle_d;
  logic [15:0]   tx_buf_q,    tx_buf_d;
  logic          tx_busy_q,   tx_busy_d;
  logic [15:0]   tx_shift_q,  tx_shift_d;
  logic [15:0]   rx_shift_q,  rx_shift_d;
  logic [4:0]    bit_cnt_q,   bit_cnt_d;
  logic [15:0]   rx_word_q,   rx_word_d;
  logic          rx_valid_q,  rx_valid_d;
  logic          underrun_q,  underrun_d;
  logic          frame_err_q, frame_err_d;
  logic          miso_q,      miso_d;

  logic spck_rise, spck_fall, ncs_rise, ncs_fall, ncs_s, mosi_s, settled;

  assign spck_rise = spck_sync_q[SYNC_STAGES-1] & ~spck_sync_q[SYNC_STAGES];
  assign spck_fall = ~spck_sync_q[SYNC_STAGES-1] & spck_sync_q[SYNC_STAGES];
  assign ncs_rise  = ncs_sync_q[SYNC_STAGES-1] & ~ncs_sync_q[SYNC_STAGES];
  assign ncs_fall  = ~ncs_sync_q[SYNC_STAGES-1] & ncs_sync_q[SYNC_STAGES];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  // Until the chain holds only real samples, an ncs "fall" may just be the
  // reset value draining out: ncs was low at reset release, so wait for high.
  assign settled   = (settle_q == SETTLE_DONE);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    spck_sync_d = {spck_sync_q[SYNC_STAGES-1:0], spck};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-1:0], ncs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-1:0], mosi};
    state_d     = state_q;
    settle_d    = settled ? settle_q : settle_q + SW'(1);
    tx_buf_d    = tx_buf_q;
    tx_busy_d   = tx_busy_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_word_d   = rx_word_q;
    rx_valid_d  = 1'b0;
    underrun_d  = underrun_q;
    frame_err_d = frame_err_q;

    // Clear first so that a set event later in this block wins.
    if (clr_err) begin
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          if (!settled) begin
            state_d = WAIT_HIGH;
          end else begin
            state_d    = ACTIVE;
            bit_cnt_d  = 5'd0;
            rx_shift_d = 16'h0000;
            if (tx_busy_q) begin
              tx_shift_d = tx_buf_q;
              tx_busy_d  = 1'b0;
            end else begin
              tx_shift_d = 16'h0000;
              underrun_d = 1'b1;
            end
          end
        end
      end

      ACTIVE: begin
        if (ncs_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == 5'd16) begin
            rx_word_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (spck_rise) begin
          rx_shift_d = {rx_shift_q[14:0], mosi_s};
          if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (spck_fall) begin
          if (bit_cnt_q >= 5'd16)     tx_shift_d = 16'h0000;
          else if (bit_cnt_q != 5'd0) tx_shift_d = {tx_shift_q[14:0], 1'b0};
        end
      end

      WAIT_HIGH: begin
        if (ncs_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A load coincident with frame start lands after the frame took the old word.
    if (tx_load) begin
      tx_buf_d  = tx_data;
      tx_busy_d = 1'b1;
    end

    miso_d = (state_d == ACTIVE) ? tx_shift_d[15] : 1'b0;
  end

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      spck_sync_q <= '0;
      ncs_sync_q  <= '1;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      settle_q    <= '0;
      tx_buf_q    <= 16'h0000;
      tx_busy_q   <= 1'b0;
      tx_shift_q  <= 16'h0000;
      rx_shift_q  <= 16'h0000;
      bit_cnt_q   <= 5'd0;
      rx_word_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      spck_sync_q <= spck_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      tx_buf_q    <= tx_buf_d;
      tx_busy_q   <= tx_busy_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_word_q   <= rx_word_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign miso      = miso_q;
  assign tx_busy   = tx_busy_q;
  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_status_tx.sv
// Directed bench for spi_status_tx: SPI frames driven at pck0/16, miso sampled
// just before each spck rise, results compared against hand-computed words.
`timescale 1ns/1ps
module tb_spi_status_tx;

  logic        pck0 = 1'b0;
  logic        nrst = 1'b0;
  logic        spck = 1'b0;
  logic        ncs  = 1'b1;
  logic        mosi = 1'b0;
  logic        tx_load = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        miso, tx_busy, rx_valid, underrun, frame_err;
  logic [15:0] rx_word;

  int n_cmp = 0;
  int n_err = 0;
  int rxv_total = 0;

  always #5 pck0 = ~pck0;

  always @(negedge pck0) if (rx_valid === 1'b1) rxv_total++;

  spi_status_tx #(.SYNC_STAGES(2)) dut (
    .pck0(pck0), .nrst(nrst), .spck(spck), .ncs(ncs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
    .rx_word(rx_word), .rx_valid(rx_valid), .underrun(underrun),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge pck0);
  endtask

  task automatic load(input logic [15:0] w);
    tx_data = w;
    tx_load = 1'b1;
    cycles(1);
    tx_load = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    cycles(1);
  endtask

  // One SPI bit: present mosi, sample miso late in the low phase, then pulse spck.
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    cycles(8);
    m = miso;
    spck = 1'b1;
    cycles(8);
    spck = 1'b0;
  endtask

  // With load_at_start the tx_load lands in the cycle the ncs fall is detected.
  task automatic frame(input logic [15:0] mw, input int nbits, input logic load_at_start,
                       input logic [15:0] lw, output logic [15:0] sent, output int pulses);
    int   base;
    logic m;
    base = rxv_total;
    sent = 16'h0000;
    ncs  = 1'b0;
    if (load_at_start) begin
      cycles(2);
      load(lw);
      cycles(5);
    end else begin
      cycles(8);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mw[15-i], m);
      sent[15-i] = m;
    end
    mosi = 1'b0;
    cycles(8);
    ncs = 1'b1;
    cycles(10);
    pulses = rxv_total - base;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    cycles(3);
    n_cmp++; if (miso !== 1'b0)         begin n_err++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_cmp++; if (tx_busy !== 1'b0)      begin n_err++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    n_cmp++; if (rx_word !== 16'h0000)  begin n_err++; $display("FAIL reset_rx_word: got %h want 0000", rx_word); end
    n_cmp++; if (rx_valid !== 1'b0)     begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (underrun !== 1'b0)     begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_cmp++; if (frame_err !== 1'b0)    begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    nrst = 1'b1;
    cycles(6);
  endtask

  task automatic test_basic();
    logic [15:0] sent;
    int          p;
    load(16'hA5C3);
    cycles(1);
    n_cmp++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_load: got %b want 1", tx_busy); end
    frame(16'h1234, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'hA5C3)     begin n_err++; $display("FAIL basic_miso: got %h want a5c3", sent); end
    n_cmp++; if (rx_word !== 16'h1234)  begin n_err++; $display("FAIL basic_rx_word: got %h want 1234", rx_word); end
    n_cmp++; if (p !== 1)               begin n_err++; $display("FAIL basic_rx_valid_count: got %0d want 1", p); end
    n_cmp++; if (tx_busy !== 1'b0)      begin n_err++; $display("FAIL basic_busy_after_frame: got %b want 0", tx_busy); end
    n_cmp++; if ({underrun, frame_err} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b want 00", {underrun, frame_err}); end
  endtask

  task automatic test_underrun();
    logic [15:0] sent;
    int          p;
    frame(16'h00FF, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'h0000)     begin n_err++; $display("FAIL underrun_miso: got %h want 0000", sent); end
    n_cmp++; if (underrun !== 1'b1)     begin n_err++; $display("FAIL underrun_set: got %b want 1", underrun); end
    n_cmp++; if (rx_word !== 16'h00FF)  begin n_err++; $display("FAIL underrun_rx_word: got %h want 00ff", rx_word); end
    pulse_clr();
    n_cmp++; if (underrun !== 1'b0)     begin n_err++; $display("FAIL underrun_clear: got %b want 0", underrun); end
  endtask

  task automatic test_short_frame();
    logic [15:0] sent;
    int          p;
    frame(16'hABCD, 9, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (frame_err !== 1'b1)    begin n_err++; $display("FAIL short_frame_err: got %b want 1", frame_err); end
    n_cmp++; if (p !== 0)               begin n_err++; $display("FAIL short_rx_valid_count: got %0d want 0", p); end
    n_cmp++; if (rx_word !== 16'h00FF)  begin n_err++; $display("FAIL short_rx_word_kept: got %h want 00ff", rx_word); end
    pulse_clr();
    load(16'h5A5A);
    frame(16'hC0DE, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'h5A5A)     begin n_err++; $display("FAIL short_next_miso: got %h want 5a5a", sent); end
    n_cmp++; if (rx_word !== 16'hC0DE)  begin n_err++; $display("FAIL short_next_rx_word: got %h want c0de", rx_word); end
    n_cmp++; if (p !== 1)               begin n_err++; $display("FAIL short_next_rx_valid: got %0d want 1", p); end
    n_cmp++; if ({underrun, frame_err} !== 2'b00) begin n_err++; $display("FAIL short_next_flags: got %b want 00", {underrun, frame_err}); end
  endtask

  task automatic test_overwrite();
    logic [15:0] sent;
    int          p;
    load(16'h0001);
    load(16'hBEEF);
    frame(16'h0F0F, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'hBEEF)     begin n_err++; $display("FAIL overwrite_miso: got %h want beef", sent); end
    n_cmp++; if (tx_busy !== 1'b0)      begin n_err++; $display("FAIL overwrite_busy: got %b want 0", tx_busy); end
    load(16'h1111);
    frame(16'h3333, 16, 1'b1, 16'h2222, sent, p);
    n_cmp++; if (sent !== 16'h1111)     begin n_err++; $display("FAIL coincident_miso: got %h want 1111", sent); end
    n_cmp++; if (tx_busy !== 1'b1)      begin n_err++; $display("FAIL coincident_busy: got %b want 1", tx_busy); end
    frame(16'h4444, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'h2222)     begin n_err++; $display("FAIL coincident_next_miso: got %h want 2222", sent); end
    n_cmp++; if (underrun !== 1'b0)     begin n_err++; $display("FAIL coincident_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_ignore_spck();
    logic [15:0] sent;
    int          p;
    load(16'h8001);
    for (int i = 0; i < 5; i++) begin
      spck = 1'b1;
      cycles(8);
      spck = 1'b0;
      cycles(8);
    end
    frame(16'h9009, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'h8001)     begin n_err++; $display("FAIL ignore_spck_miso: got %h want 8001", sent); end
    n_cmp++; if (rx_word !== 16'h9009)  begin n_err++; $display("FAIL ignore_spck_rx_word: got %h want 9009", rx_word); end
    n_cmp++; if (frame_err !== 1'b0)    begin n_err++; $display("FAIL ignore_spck_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] sent;
    logic        m;
    logic        miso_any;
    int          base;
    int          p;
    pulse_clr();
    load(16'h3C3C);
    base = rxv_total;
    ncs  = 1'b0;
    cycles(8);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    nrst = 1'b0;
    cycles(2);
    n_cmp++; if (miso !== 1'b0)         begin n_err++; $display("FAIL midrst_miso_in_reset: got %b want 0", miso); end
    n_cmp++; if (tx_busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy_discarded: got %b want 0", tx_busy); end
    n_cmp++; if (rx_word !== 16'h0000)  begin n_err++; $display("FAIL midrst_rx_word: got %h want 0000", rx_word); end
    nrst = 1'b1;
    miso_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'b1, m);
      miso_any = miso_any | m;
    end
    mosi = 1'b0;
    cycles(8);
    ncs = 1'b1;
    cycles(10);
    n_cmp++; if (miso_any !== 1'b0)     begin n_err++; $display("FAIL midrst_miso_after: got %b want 0", miso_any); end
    n_cmp++; if ({underrun, frame_err} !== 2'b00) begin n_err++; $display("FAIL midrst_no_frame_flags: got %b want 00", {underrun, frame_err}); end
    n_cmp++; if (rxv_total - base !== 0) begin n_err++; $display("FAIL midrst_rx_valid: got %0d want 0", rxv_total - base); end
    frame(16'h6B6B, 16, 1'b0, 16'h0000, sent, p);
    n_cmp++; if (sent !== 16'h0000)     begin n_err++; $display("FAIL midrst_next_miso: got %h want 0000", sent); end
    n_cmp++; if (underrun !== 1'b1)     begin n_err++; $display("FAIL midrst_next_underrun: got %b want 1", underrun); end
    n_cmp++; if (rx_word !== 16'h6B6B)  begin n_err++; $display("FAIL midrst_next_rx_word: got %h want 6b6b", rx_word); end
    n_cmp++; if (p !== 1)               begin n_err++; $display("FAIL midrst_next_rx_valid: got %0d want 1", p); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_short_frame();
    test_overwrite();
    test_ignore_spck();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached after %0d compares", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
